// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package wb_arb_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int NUM_REGS = 32;

  // Queue entry bookkeeping. The data word is kept next to this record in the
  // FIFO because its width is a module parameter.
  typedef struct packed {
    logic       live;
    logic [4:0] rd;
  } entryTag_t;

  function automatic logic [NUM_REGS-1:0] regOneHot(input logic [4:0] r);
    return NUM_REGS'(1) << r;
  endfunction

endpackage

// File: rtl/wb_llu_fifo.sv
// Small LLU result queue: pointer/count FIFO with per-entry kill by destination
// register and a mask of registers still targeted by live entries.
module wb_llu_fifo
  import wb_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic [4:0]          pushReg,
  input  logic [WIDTH-1:0]    pushData,
  input  logic                pop,
  input  logic                killEn,
  input  logic [4:0]          killReg,
  output logic [CW-1:0]       count,
  output entryTag_t           headTag,
  output logic [WIDTH-1:0]    headData,
  output logic [NUM_REGS-1:0] liveMask
);

  typedef struct packed {
    entryTag_t        tag;
    logic [WIDTH-1:0] data;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] rdPtr;
  logic [PW-1:0] wrPtr;

  // Slots outside the occupied window always hold live=0, so the head tag of
  // an empty queue reads as dead and the mask can OR over every slot.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i].tag.live <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (killEn && mem[i].tag.rd == killReg) mem[i].tag.live <= 1'b0;
      if (pop) begin
        mem[rdPtr].tag.live <= 1'b0;
        rdPtr <= rdPtr + 1'b1;
      end
      // Push only lands when count<DEPTH, so the tail slot is never the head.
      if (push) begin
        mem[wrPtr].tag.live <= 1'b1;
        mem[wrPtr].tag.rd   <= pushReg;
        mem[wrPtr].data     <= pushData;
        wrPtr <= wrPtr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign headTag  = mem[rdPtr].tag;
  assign headData = mem[rdPtr].data;

  // Busy mask: one-hot destination of every live entry.
  always_comb begin
    liveMask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (mem[i].tag.live) liveMask = liveMask | regOneHot(mem[i].tag.rd);
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter between pipeline writeback and a
// long-latency unit. Optional starvation guard: WB_STARVE_GUARD_EN.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int width    = 32,
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wb_valid,
  input  logic [4:0]          wb_reg,
  input  logic [width-1:0]    wb_data,
  input  logic                llu_valid,
  input  logic [4:0]          llu_reg,
  input  logic [width-1:0]    llu_data,
  output logic                llu_ready,
  output logic                rf_we,
  output logic [4:0]          rf_wa,
  output logic [width-1:0]    rf_wd,
  output logic                stall_req,
  output logic [NUM_REGS-1:0] busy_mask
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]       count;
  entryTag_t           headTag;
  logic [width-1:0]    headData;
  logic [NUM_REGS-1:0] liveMask;
  logic                lluAcc, push, pop, popLive, killEn, bypass, starve;
  logic                portWe;
  logic [4:0]          portWa;
  logic [width-1:0]    portWd;

  wb_llu_fifo #(.WIDTH(width), .DEPTH(DEPTH)) uFifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pushReg  (llu_reg),
    .pushData (llu_data),
    .pop      (pop),
    .killEn   (killEn),
    .killReg  (wb_reg),
    .count    (count),
    .headTag  (headTag),
    .headData (headData),
    .liveMask (liveMask)
  );

  // No same-cycle pop credit: acceptance depends on registered count only.
  assign llu_ready = !reset || (count < CW'(DEPTH));
  assign lluAcc    = llu_valid && llu_ready;

`ifdef WB_STARVE_GUARD_EN
  localparam int AW = $clog2(MAX_WAIT + 1);
  logic [AW-1:0] age;

  assign starve = headTag.live && (age == AW'(MAX_WAIT));

  // Age of the live head; dead heads and pops restart it, saturates at MAX_WAIT.
  always_ff @(posedge clk) begin
    if (!reset || !headTag.live || pop) age <= '0;
    else if (age != AW'(MAX_WAIT))      age <= age + 1'b1;
  end
`else
  assign starve = 1'b0;
`endif

  assign stall_req = reset && starve;

  // Port priority: starved head, pipeline, live head, then empty-queue bypass.
  always_comb begin
    portWe  = 1'b0;
    portWa  = REG_ZERO;
    portWd  = '0;
    popLive = 1'b0;
    killEn  = 1'b0;
    bypass  = 1'b0;
    if (stall_req) begin
      portWe  = 1'b1;
      portWa  = headTag.rd;
      portWd  = headData;
      popLive = 1'b1;
    end else if (wb_valid && wb_reg != REG_ZERO) begin
      portWe  = 1'b1;
      portWa  = wb_reg;
      portWd  = wb_data;
      killEn  = 1'b1;
    end else if (headTag.live) begin
      portWe  = 1'b1;
      portWa  = headTag.rd;
      portWd  = headData;
      popLive = 1'b1;
    end else if (count == '0 && lluAcc && llu_reg != REG_ZERO) begin
      portWe  = 1'b1;
      portWa  = llu_reg;
      portWd  = llu_data;
      bypass  = 1'b1;
    end
    // A same-cycle pipeline write to the same register supersedes the older
    // LLU result, so it is accepted but never queued.
    push = lluAcc && llu_reg != REG_ZERO && !bypass && !(killEn && wb_reg == llu_reg);
    // Dead heads drain at one per cycle without touching the port.
    pop  = popLive || (count != '0 && !headTag.live);
  end

  assign rf_we     = reset && portWe;
  assign rf_wa     = rf_we ? portWa : REG_ZERO;
  assign rf_wd     = rf_we ? portWd : '0;
  assign busy_mask = reset ? liveMask : '0;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter (default parameters). Inputs change just
// after the falling edge; combinational outputs are checked 1ns later.
module tb_wb_port_arbiter;

`ifdef WB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid, llu_valid;
  logic [4:0]  wb_reg, llu_reg;
  logic [31:0] wb_data, llu_data;
  logic        llu_ready, rf_we, stall_req;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [31:0] busy_mask;

  int nChk = 0;
  int nBad = 0;

  always #5 clk = ~clk;

  wb_port_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .wb_valid  (wb_valid),
    .wb_reg    (wb_reg),
    .wb_data   (wb_data),
    .llu_valid (llu_valid),
    .llu_reg   (llu_reg),
    .llu_data  (llu_data),
    .llu_ready (llu_ready),
    .rf_we     (rf_we),
    .rf_wa     (rf_wa),
    .rf_wd     (rf_wd),
    .stall_req (stall_req),
    .busy_mask (busy_mask)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChk++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic portChk(input string tag, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd);
    chk({tag, ".we"}, 64'(rf_we), 64'(we));
    chk({tag, ".wa"}, 64'(rf_wa), 64'(wa));
    chk({tag, ".wd"}, 64'(rf_wd), 64'(wd));
  endtask

  task automatic drv(input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                     input logic lv, input logic [4:0] lr, input logic [31:0] ld);
    @(negedge clk);
    wb_valid = wv; wb_reg = wr; wb_data = wd;
    llu_valid = lv; llu_reg = lr; llu_data = ld;
    #1;
  endtask

  initial begin
    reset = 1'b0;
    wb_valid = 1'b0; wb_reg = 5'd0; wb_data = 32'h0;
    llu_valid = 1'b1; llu_reg = 5'd5; llu_data = 32'hAA;

    // Reset held two cycles with an LLU result waiting
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      chk("rst.we", 64'(rf_we), 64'd0);
      chk("rst.stall", 64'(stall_req), 64'd0);
      chk("rst.busy", 64'(busy_mask), 64'd0);
      chk("rst.ready", 64'(llu_ready), 64'd1);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    portChk("bypass", 1'b1, 5'd5, 32'hAA);
    chk("bypass.ready", 64'(llu_ready), 64'd1);
    drv(0, 0, 0, 0, 0, 0);
    portChk("bypass.after", 1'b0, 5'd0, 32'h0);
    chk("bypass.busy", 64'(busy_mask), 64'd0);

    // Pipeline wins, LLU queued then drained on an idle cycle
    drv(1, 3, 32'h11, 1, 7, 32'h22);
    portChk("conf", 1'b1, 5'd3, 32'h11);
    chk("conf.ready", 64'(llu_ready), 64'd1);
    drv(0, 0, 0, 0, 0, 0);
    portChk("drain7", 1'b1, 5'd7, 32'h22);
    chk("drain7.busy", 64'(busy_mask), 64'h80);
    drv(0, 0, 0, 0, 0, 0);
    portChk("drain7.after", 1'b0, 5'd0, 32'h0);
    chk("drain7.busy0", 64'(busy_mask), 64'd0);

    // Fill the queue while the pipeline is busy; third result must wait
    drv(1, 1, 32'h1, 1, 8, 32'h8);
    portChk("fill8", 1'b1, 5'd1, 32'h1);
    drv(1, 2, 32'h2, 1, 9, 32'h9);
    portChk("fill9", 1'b1, 5'd2, 32'h2);
    chk("fill9.busy", 64'(busy_mask), 64'h100);
    drv(1, 1, 32'h3, 1, 10, 32'h10);
    chk("full.ready", 64'(llu_ready), 64'd0);
    chk("full.busy", 64'(busy_mask), 64'h300);
    portChk("full.wb", 1'b1, 5'd1, 32'h3);
    drv(1, 2, 32'h4, 1, 10, 32'h10);
    chk("full2.ready", 64'(llu_ready), 64'd0);
    portChk("full2.wb", 1'b1, 5'd2, 32'h4);
    drv(0, 0, 0, 1, 10, 32'h10);
    chk("pop8.ready", 64'(llu_ready), 64'd0);
    portChk("pop8", 1'b1, 5'd8, 32'h8);
    drv(0, 0, 0, 1, 10, 32'h10);
    chk("pop9.ready", 64'(llu_ready), 64'd1);
    portChk("pop9", 1'b1, 5'd9, 32'h9);
    chk("pop9.busy", 64'(busy_mask), 64'h200);
    drv(0, 0, 0, 0, 0, 0);
    portChk("pop10", 1'b1, 5'd10, 32'h10);
    chk("pop10.busy", 64'(busy_mask), 64'h400);
    drv(0, 0, 0, 0, 0, 0);
    portChk("fill.done", 1'b0, 5'd0, 32'h0);
    chk("fill.busy0", 64'(busy_mask), 64'd0);

    // WAW kill of a queued entry
    drv(1, 1, 32'h5, 1, 4, 32'h33);
    portChk("waw.q", 1'b1, 5'd1, 32'h5);
    drv(1, 4, 32'h44, 0, 0, 0);
    portChk("waw.wr", 1'b1, 5'd4, 32'h44);
    chk("waw.busy", 64'(busy_mask), 64'h10);
    drv(0, 0, 0, 0, 0, 0);
    portChk("waw.dead", 1'b0, 5'd0, 32'h0);
    chk("waw.busy0", 64'(busy_mask), 64'd0);
    drv(0, 0, 0, 0, 0, 0);
    portChk("waw.empty", 1'b0, 5'd0, 32'h0);
    chk("waw.ready", 64'(llu_ready), 64'd1);

    // Starvation: live head r6 behind a continuously busy pipeline
    drv(1, 1, 32'h6, 1, 6, 32'h66);
    portChk("st.q", 1'b1, 5'd1, 32'h6);
    for (int i = 1; i <= 6; i++) begin
      logic hit;
      hit = GUARD && (i == 5);
      drv(1, 2, 32'h55, 0, 0, 0);
      chk($sformatf("st%0d.stall", i), 64'(stall_req), 64'(hit));
      portChk($sformatf("st%0d", i), 1'b1, hit ? 5'd6 : 5'd2, hit ? 32'h66 : 32'h55);
      chk($sformatf("st%0d.busy", i), 64'(busy_mask), (GUARD && i == 6) ? 64'd0 : 64'h40);
    end
    drv(0, 0, 0, 0, 0, 0);
    portChk("st.idle", !GUARD, GUARD ? 5'd0 : 5'd6, GUARD ? 32'h0 : 32'h66);
    drv(0, 0, 0, 0, 0, 0);
    portChk("st.done", 1'b0, 5'd0, 32'h0);
    chk("st.stall0", 64'(stall_req), 64'd0);

    // Register zero on both sources, then same-cycle WAW drop of the LLU
    drv(1, 0, 32'h77, 1, 0, 32'h88);
    portChk("r0", 1'b0, 5'd0, 32'h0);
    chk("r0.ready", 64'(llu_ready), 64'd1);
    chk("r0.busy", 64'(busy_mask), 64'd0);
    drv(0, 0, 0, 0, 0, 0);
    portChk("r0.after", 1'b0, 5'd0, 32'h0);
    chk("r0.busy0", 64'(busy_mask), 64'd0);
    drv(1, 12, 32'hC1, 1, 12, 32'hC2);
    portChk("samewaw", 1'b1, 5'd12, 32'hC1);
    drv(0, 0, 0, 0, 0, 0);
    portChk("samewaw.after", 1'b0, 5'd0, 32'h0);
    chk("samewaw.busy", 64'(busy_mask), 64'd0);

    $display("test done: total=%0d bad=%0d", nChk, nBad);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
Shares the single register-file write port between the in-order pipeline writeback (regWrite_W/writeReg_W/result_W from the writeback stage) and a long-latency unit (LLU, e.g. mul/div) that completes out of band. LLU results that cannot write immediately wait in a small queue. The block drives the register-file write port, exports a busy mask to the hazard unit, and can request a one-cycle writeback stall to prevent LLU starvation.

Parameters:
width, 32, data width of register-file write data
DEPTH, 2, LLU result queue entries (power of two, >=2)
MAX_WAIT, 4, cycles a live queue head may wait before the starvation guard fires

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous reset, active-low (state cleared on clk edge while reset==0)
wb_valid  in  1  pipeline writeback request (regWrite_W)
wb_reg  in  5  pipeline destination register (writeReg_W)
wb_data  in  width  pipeline result (result_W)
llu_valid  in  1  LLU result available
llu_reg  in  5  LLU destination register
llu_data  in  width  LLU result
llu_ready  out  1  LLU result accepted this cycle when llu_valid&&llu_ready
rf_we  out  1  register-file write enable
rf_wa  out  5  register-file write address
rf_wd  out  width  register-file write data
stall_req  out  1  holds pipeline writeback this cycle (OR into stall_W)
busy_mask  out  32  bit R set while a live queued entry targets R

Behaviour:
- Reset (reset==0 at edge): queue empty, all entries dead, age counter 0. While queue state is reset: rf_we=0, stall_req=0, busy_mask=0, llu_ready=1; rf_wa/rf_wd are don't-care when rf_we=0 (drive 0).
- llu_ready = (count < DEPTH), from registered count only; no same-cycle pop credit.
- Writes to register 0 never assert rf_we. LLU results for reg 0 are accepted and dropped, never enqueued.
- Port priority, evaluated combinationally each cycle; writes take effect the same cycle (zero latency):
  1. stall_req=1: port takes the live queue head; the pipeline request is ignored (stage is held and re-presents next cycle).
  2. Else wb_valid && wb_reg!=0: port takes the pipeline request.
  3. Else live queue head present: port takes the head and pops it.
  4. Else queue empty and LLU accepted with llu_reg!=0: direct write of the LLU result (bypass, no enqueue).
- Enqueue: an accepted LLU result not written directly goes to the tail. Push and pop in the same cycle are legal; count is unchanged.
- WAW kill: a pipeline write to R (case 2) marks dead every queued entry with reg==R. A same-cycle accepted LLU result for R is also dropped (LLU is older in program order).
- Dead head: popped at the next edge without rf_we, regardless of port use. At most one pop per cycle. A dead head does not count toward age.
- Age counter: increments each cycle a live head is not written, clears on pop or when the head is dead, and saturates at MAX_WAIT.
- busy_mask: combinational OR of the one-hot regs of live entries.
- Mid-operation reset discards queued results; losing in-flight LLU data is the intended behaviour.

Optional Feature:
WB_STARVE_GUARD_EN
- Defined: stall_req = live head && age==MAX_WAIT. It stays high for exactly one cycle, the head drains via case 1, then age clears.
- Undefined: stall_req is tied 0 and the age counter is removed. The queue drains only on pipeline-idle cycles, and LLU backpressure is via llu_ready alone.

Decomposition:
- Package wb_arb_pkg: entry record {live, reg[4:0], data[width-1:0]}, REG_ZERO=5'd0, NUM_REGS=32.
- Sub-module wb_llu_fifo: DEPTH-entry synchronous FIFO with ptr/count, per-entry kill-by-address compare, and a live-reg mask output. Priority mux, age counter and guard stay in the top.

Test Plan:
- Reset held low 2 cycles with llu_valid=1 -> rf_we=0, stall_req=0, busy_mask=0, llu_ready=1; after release, the first LLU result (reg 5, 0xAA) writes directly in the same cycle.
- wb_valid=1 reg 3 = 0x11 and llu_valid=1 reg 7 = 0x22 in the same cycle -> rf writes r3=0x11; r7 queued, busy_mask=0x80; next pipeline-idle cycle rf writes r7=0x22, busy_mask=0.
- Queue full (DEPTH=2, regs 8,9) with pipeline busy every cycle -> llu_ready=0; a third llu_valid is held until a pop, with no loss or duplication.
- Queued r4=0x33, then pipeline writes r4=0x44 -> entry killed, busy_mask bit4 clears, rf never writes 0x33, final r4=0x44.
- With WB_STARVE_GUARD_EN, MAX_WAIT=4, live head r6 and wb_valid continuous -> stall_req high exactly on the 5th cycle, rf writes r6 that cycle, pipeline write lands the next cycle; without the macro, stall_req stays 0.
- llu_valid reg 0 and wb_valid reg 0 -> rf_we stays 0, nothing enqueued, llu_ready stays 1.
